// File: rtl/datapath_sequencer.sv
// Command sequencer driving a register-file datapath: single-cycle LDI/MOV/RD/NOP
// execution, a four-write FILL burst, and a one-cycle completion response.
module datapath_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_rd,
  input  logic [1:0]  cmd_ra,
  input  logic [1:0]  cmd_rb,
  input  logic [31:0] cmd_imm,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        dp_enable,
  output logic        dp_write,
  output logic [1:0]  dp_dsel,
  output logic [1:0]  dp_asel,
  output logic [1:0]  dp_bsel,
  output logic        dp_mb,
  output logic        dp_md,
  output logic [31:0] dp_din,
  input  logic [31:0] dp_dout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_RD   = 3'b011;
  localparam logic [2:0] OP_FILL = 3'b100;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [31:0] imm_q, imm_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        dp_enable_q, dp_enable_d;
  logic        dp_write_q, dp_write_d;
  logic [1:0]  dp_dsel_q, dp_dsel_d;
  logic [1:0]  dp_asel_q, dp_asel_d;
  logic [1:0]  dp_bsel_q, dp_bsel_d;
  logic        dp_mb_q, dp_mb_d;
  logic        dp_md_q, dp_md_d;
  logic [31:0] dp_din_q, dp_din_d;
  logic        accept_s;

  // Next-state, command latch and FILL counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    imm_d    = imm_q;
    accept_s = cmd_valid && cmd_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          ra_d    = cmd_ra;
          rb_d    = cmd_rb;
          imm_d   = cmd_imm;
          cnt_d   = 2'd0;
          state_d = (cmd_op == OP_FILL) ? ST_FILL : ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_FILL: begin
        // Counter stops at 3 and the burst ends there, so no fifth write.
        if (cnt_q == 2'd3) begin
          state_d = ST_RESP;
          cnt_d   = 2'd0;
        end else begin
          cnt_d   = cnt_q + 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the flops present them during that state.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    dp_enable_d = 1'b1;
    dp_write_d  = 1'b0;
    dp_dsel_d   = 2'd0;
    dp_asel_d   = 2'd0;
    dp_bsel_d   = 2'd0;
    dp_mb_d     = 1'b0;
    dp_md_d     = 1'b0;
    dp_din_d    = 32'd0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_d)
      ST_EXEC: begin
        case (op_d)
          OP_LDI: begin
            dp_write_d = 1'b1;
            dp_md_d    = 1'b1;
            dp_dsel_d  = rd_d;
            dp_din_d   = imm_d;
          end
          OP_MOV: begin
            dp_write_d = 1'b1;
            dp_dsel_d  = rd_d;
            dp_asel_d  = ra_d;
            dp_bsel_d  = ra_d;
          end
          OP_RD: begin
            dp_asel_d = ra_d;
            dp_bsel_d = rb_d;
          end
          default: dp_write_d = 1'b0;
        endcase
      end
      ST_FILL: begin
        dp_write_d = 1'b1;
        dp_md_d    = 1'b1;
        dp_dsel_d  = cnt_d;
        dp_din_d   = imm_d;
      end
      default: dp_write_d = 1'b0;
    endcase
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      rsp_data_d = ((state_q == ST_EXEC) && (op_q == OP_RD)) ? dp_dout : 32'd0;
      rsp_err_d  = (state_q == ST_EXEC) && (op_q > OP_FILL);
    end else begin
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
    end
  end

  // State, command fields and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      op_q        <= OP_NOP;
      rd_q        <= 2'd0;
      ra_q        <= 2'd0;
      rb_q        <= 2'd0;
      imm_q       <= 32'd0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
      dp_enable_q <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_dsel_q   <= 2'd0;
      dp_asel_q   <= 2'd0;
      dp_bsel_q   <= 2'd0;
      dp_mb_q     <= 1'b0;
      dp_md_q     <= 1'b0;
      dp_din_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      imm_q       <= imm_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      dp_enable_q <= dp_enable_d;
      dp_write_q  <= dp_write_d;
      dp_dsel_q   <= dp_dsel_d;
      dp_asel_q   <= dp_asel_d;
      dp_bsel_q   <= dp_bsel_d;
      dp_mb_q     <= dp_mb_d;
      dp_md_q     <= dp_md_d;
      dp_din_q    <= dp_din_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dp_enable = dp_enable_q;
  assign dp_write  = dp_write_q;
  assign dp_dsel   = dp_dsel_q;
  assign dp_asel   = dp_asel_q;
  assign dp_bsel   = dp_bsel_q;
  assign dp_mb     = dp_mb_q;
  assign dp_md     = dp_md_q;
  assign dp_din    = dp_din_q;

endmodule
